// File: rtl/weight_load_sequencer.sv
// Steers a valid/ready word stream into a bank of NumRegs enable-loaded registers, one word per slot.
// IDLE: wait for start | LOAD: accept words, strobe one slot per transfer | DONE: one-cycle done pulse
module weight_load_sequencer #(
  parameter int Width   = 24,
  parameter int NumRegs = 8,
  parameter int IdxW    = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [Width-1:0]   in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [Width-1:0]   reg_data_o,
  output logic [NumRegs-1:0] reg_enable_o,
  output logic [IdxW-1:0]    reg_index_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumRegs - 1);

  state_t              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [Width-1:0]    data_q, data_d;
  logic [NumRegs-1:0]  en_q, en_d;
  logic                xfer;

  assign xfer = in_valid_i && (state_q == LOAD);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    en_d    = '0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (xfer) begin
          data_d = in_data_i;
          en_d   = NumRegs'(1) << idx_q;
          if (idx_q == LastIdx) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      en_q    <= en_d;
    end
  end

  // done coincides with the final strobe because DONE is entered on the last transfer
  assign in_ready_o   = (state_q == LOAD);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign reg_data_o   = data_q;
  assign reg_enable_o = en_q;
  assign reg_index_o  = idx_q;

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Scoreboard bench: the driver predicts each slot strobe from its own transfer count,
// a negedge monitor pops and compares whenever a strobe or done appears.
module tb_weight_load_sequencer;

  localparam int W  = 24;
  localparam int NR = 8;
  localparam int IW = 3;

  logic          clk;
  logic          reset_i, start_i, in_valid_i;
  logic [W-1:0]  in_data_i;
  logic          in_ready_o, busy_o, done_o;
  logic [W-1:0]  reg_data_o;
  logic [NR-1:0] reg_enable_o;
  logic [IW-1:0] reg_index_o;

  typedef struct {
    logic [NR-1:0] en;
    logic [W-1:0]  data;
    logic          done;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  weight_load_sequencer #(.Width(W), .NumRegs(NR), .IdxW(IW)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .reg_data_o  (reg_data_o),
    .reg_enable_o(reg_enable_o),
    .reg_index_o (reg_index_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: any strobe or done pulse must match the oldest predicted transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reg_enable_o !== '0 || done_o === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", {reg_enable_o, done_o}, 0);
        end else begin
          e = sb.pop_front();
          chk("strobe_enable", reg_enable_o, e.en);
          chk("strobe_data", reg_data_o, e.data);
          chk("strobe_done", done_o, e.done);
        end
      end
    end
  end

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_enable"}, reg_enable_o, 0);
    chk({tag, "_index"}, reg_index_o, 0);
    chk({tag, "_data"}, reg_data_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_ready"}, in_ready_o, 0);
    chk({tag, "_done"}, done_o, 0);
  endtask

  // vmode: 0 always valid, 1 alternating 1/0, 2 random.
  // dmode: 0 random words, 1 words -1..-8, 2 first word 24'h123456.
  task automatic load_seq(input int vmode, input int dmode, input int start_at, input int abort_at);
    int k = 0;
    int cyc_n = 0;
    logic v;
    logic [W-1:0] w;
    start_i    = 1'b1;
    in_valid_i = 1'($urandom_range(0, 1));
    in_data_i  = W'($urandom);
    step();
    while (k < NR) begin
      if (k == abort_at) begin
        reset_i    = 1'b1;
        start_i    = 1'($urandom_range(0, 1));
        in_valid_i = 1'b1;
        in_data_i  = W'($urandom);
        step();
        reset_i    = 1'b0;
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        chk_idle_zero("abort");
        return;
      end
      chk("load_ready", in_ready_o, 1);
      chk("load_busy", busy_o, 1);
      chk("load_index", reg_index_o, k);
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc_n % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      if (dmode == 1)                w = W'(-(k + 1));
      else if (dmode == 2 && k == 0) w = 24'h123456;
      else                           w = W'($urandom);
      in_valid_i = v;
      in_data_i  = w;
      start_i    = (k == start_at) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
      if (v) begin
        sb.push_back('{en: NR'(1) << k, data: w, done: (k == NR - 1)});
        k++;
      end
      cyc_n++;
      step();
    end
    in_valid_i = 1'($urandom_range(0, 1));
    start_i    = 1'($urandom_range(0, 1));
    in_data_i  = W'($urandom);
    chk("done_ready", in_ready_o, 0);
    chk("done_busy", busy_o, 1);
    chk("done_index", reg_index_o, 0);
    step();
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    chk("idle_busy", busy_o, 0);
    chk("idle_ready", in_ready_o, 0);
    chk("idle_done", done_o, 0);
  endtask

  initial begin
    reset_i    = 1'b1;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    repeat (2) begin
      start_i    = 1'($urandom_range(0, 1));
      in_valid_i = 1'($urandom_range(0, 1));
      in_data_i  = W'($urandom);
      step();
    end
    chk_idle_zero("reset");
    reset_i    = 1'b0;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    step();

    // valid without start must never be accepted
    repeat (4) begin
      in_valid_i = 1'b1;
      in_data_i  = W'($urandom);
      step();
      chk("idle_ready_nostart", in_ready_o, 0);
      chk("idle_enable_nostart", reg_enable_o, 0);
      chk("idle_index_nostart", reg_index_o, 0);
      chk("idle_busy_nostart", busy_o, 0);
    end
    in_valid_i = 1'b0;
    step();

    load_seq(0, 1, -1, -1);
    step();
    load_seq(1, 0, -1, -1);
    load_seq(0, 0, 3, -1);
    step();
    load_seq(0, 0, -1, 4);
    step();
    load_seq(2, 2, -1, -1);
    repeat (6) begin
      repeat ($urandom_range(0, 2)) step();
      load_seq(2, 0, -1, -1);
    end

    repeat (3) step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
